// File: rtl/div_pkg.sv
// Shared types and constants for the divider issue controller and its result FIFO.
package div_pkg;

  typedef enum logic {
    StIdle,
    StDrive
  } state_e;

  typedef struct packed {
    logic [2:0] q;
    logic [2:0] r;
    logic       dbz;
    logic       ovf;
  } result_t;

  localparam int unsigned EntryW = $bits(result_t);

  localparam logic [2:0] Q_SAT = 3'b111;
  localparam logic [2:0] R_ERR = 3'b000;

  // Returns {dbz, ovf}; only Y=1 can push a 4-bit dividend past the 3-bit quotient.
  function automatic logic [1:0] screen(input logic [3:0] x, input logic [1:0] y);
    logic dbz;
    logic ovf;
    dbz = (y == 2'd0);
    ovf = (y == 2'd1) & x[3];
    return {dbz, ovf};
  endfunction

endpackage

// File: rtl/div_issue_ctrl_if.sv
// Request and result handshake bundle between a requester/consumer and the issue controller.
interface div_issue_ctrl_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_x;
  logic [1:0] in_y;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_q;
  logic [2:0] out_r;
  logic       out_dbz;
  logic       out_ovf;

  modport master (
    output in_valid, in_x, in_y, out_ready,
    input  in_ready, out_valid, out_q, out_r, out_dbz, out_ovf
  );

  modport slave (
    input  in_valid, in_x, in_y, out_ready,
    output in_ready, out_valid, out_q, out_r, out_dbz, out_ovf
  );
endinterface

// File: rtl/div_result_fifo.sv
// In-order circular result buffer; head entry is presented combinationally.
module div_result_fifo
  import div_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_push,
  input  result_t         i_data,
  input  logic            i_pop,
  output result_t         o_head,
  output logic [CntW-1:0] o_count,
  output logic            o_full,
  output logic            o_empty
);

  result_t         r_mem [DEPTH];
  logic [PtrW-1:0] r_wr;
  logic [PtrW-1:0] r_rd;
  logic [CntW-1:0] r_count;
  logic            w_push;
  logic            w_pop;

  function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_full  = (r_count == CntW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd];

  // Pop on empty and push on full are dropped rather than corrupting the pointers.
  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= ptr_next(r_wr);
      end
      if (w_pop) begin
        r_rd <= ptr_next(r_rd);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/div_issue_ctrl.sv
// Screens divide requests, drives clean operands into the array divider, and buffers results.
module div_issue_ctrl
  import div_pkg::*;
#(
  parameter int unsigned SETTLE = 1,
  parameter int unsigned DEPTH  = 2
) (
  input  logic             clk,
  input  logic             reset,
  div_issue_ctrl_if.slave  bus,
  output logic [3:0]       div_x,
  output logic [1:0]       div_y,
  input  logic [2:0]       div_q,
  input  logic [2:0]       div_r
);

  localparam int unsigned SetW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  state_e          r_state;
  logic [SetW-1:0] r_cnt;
  logic [3:0]      r_div_x;
  logic [1:0]      r_div_y;
  result_t         r_hold;

  logic            w_in_ready;
  logic            w_accept;
  logic [1:0]      w_flags;
  logic            w_err;
  logic            w_push;
  result_t         w_push_data;
  logic            w_pop;
  result_t         w_head;
  logic [CntW-1:0] w_count;
  logic            w_full;
  logic            w_empty;

  assign w_in_ready = ~reset & (r_state == StIdle) & ~w_full;
  assign w_accept   = bus.in_valid & w_in_ready;
  assign w_flags    = screen(bus.in_x, bus.in_y);
  assign w_err      = |w_flags;
  assign w_pop      = bus.out_ready & ~w_empty;

  // Error requests bypass the divider; they can never collide with a capture since
  // acceptance only happens in idle.
  always_comb begin
    w_push      = 1'b0;
    w_push_data = '0;
    if (w_accept && w_err) begin
      w_push      = 1'b1;
      w_push_data = '{q: Q_SAT, r: R_ERR, dbz: w_flags[1], ovf: w_flags[0]};
    end else if (r_state == StDrive && r_cnt == '0) begin
      w_push      = 1'b1;
      w_push_data = '{q: div_q, r: div_r, dbz: 1'b0, ovf: 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_div_x <= '0;
      r_div_y <= '0;
      r_hold  <= '0;
    end else begin
      if (w_pop) begin
        r_hold <= w_head;
      end
      unique case (r_state)
        StIdle: begin
          if (w_accept && !w_err) begin
            r_div_x <= bus.in_x;
            r_div_y <= bus.in_y;
            r_cnt   <= SetW'(SETTLE - 1);
            r_state <= StDrive;
          end
        end
        StDrive: begin
          if (r_cnt == '0) begin
            r_state <= StIdle;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  div_result_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  result_t w_out;
  // While empty the outputs keep showing the last consumed entry instead of stale memory.
  assign w_out         = w_empty ? r_hold : w_head;
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (w_count != '0);
  assign bus.out_q     = w_out.q;
  assign bus.out_r     = w_out.r;
  assign bus.out_dbz   = w_out.dbz;
  assign bus.out_ovf   = w_out.ovf;
  assign div_x         = r_div_x;
  assign div_y         = r_div_y;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Scoreboard bench for div_issue_ctrl with a behavioural array divider on the div_* ports.
module tb_div_issue_ctrl;

  logic       clk;
  logic       reset;
  logic [3:0] div_x;
  logic [1:0] div_y;
  logic [2:0] div_q;
  logic [2:0] div_r;
  logic [3:0] w_q4;
  logic [3:0] w_r4;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q [$];
  bit rand_en = 0;

  div_issue_ctrl_if bus ();

  div_issue_ctrl #(
    .SETTLE (1),
    .DEPTH  (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .div_x (div_x),
    .div_y (div_y),
    .div_q (div_q),
    .div_r (div_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Array divider stand-in; Y=0 output is arbitrary because it must never be sampled.
  always_comb begin
    w_q4 = 4'd0;
    w_r4 = 4'd0;
    if (div_y != 2'd0) begin
      w_q4 = div_x / {2'b00, div_y};
      w_r4 = div_x % {2'b00, div_y};
    end
    div_q = w_q4[2:0];
    div_r = w_r4[2:0];
  end

  function automatic logic [7:0] mk(input int q, input int r, input bit d, input bit o);
    logic [2:0] q3;
    logic [2:0] r3;
    q3 = q[2:0];
    r3 = r[2:0];
    return {q3, r3, d, o};
  endfunction

  function automatic logic [7:0] model(input int x, input int y);
    if (y == 0) return mk(7, 0, 1'b1, 1'b0);
    if (y == 1 && x > 7) return mk(7, 0, 1'b0, 1'b1);
    return mk(x / y, x % y, 1'b0, 1'b0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Holds the request until accepted; returns 1 ns after the accepting edge.
  task automatic send(input int x, input int y, input logic [7:0] exp, input bit track);
    bit ok;
    ok = 0;
    bus.in_valid = 1'b1;
    bus.in_x     = 4'(x);
    bus.in_y     = 2'(y);
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      chk("accept_timeout", 32'd0, 32'd1);
      bus.in_valid = 1'b0;
    end else begin
      @(posedge clk);
      if (track) exp_q.push_back(exp);
      #1;
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bus.out_valid) begin
        ok = 1;
        break;
      end
    end
    chk("drain", 32'(ok), 32'd1);
    step();
  endtask

  // Monitor: every pop the DUT performs is compared against the oldest expectation.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (!reset && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", {bus.out_q, bus.out_r, bus.out_dbz, bus.out_ovf}, 32'hFFFF);
        end else begin
          e = exp_q.pop_front();
          chk("result", {bus.out_q, bus.out_r, bus.out_dbz, bus.out_ovf}, e);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_x      = '0;
    bus.in_y      = '0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("in_ready_in_reset", 32'(bus.in_ready), 32'd0);
    step();
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("reset_state", {bus.out_valid, bus.out_q, bus.out_r, bus.out_dbz, bus.out_ovf,
                        div_x, div_y}, 32'd0);
    chk("in_ready_after_reset", 32'(bus.in_ready), 32'd1);
    step();

    // Normal request: one busy cycle, result visible after the capture edge.
    send(13, 3, mk(4, 1, 0, 0), 1);
    @(negedge clk);
    chk("busy_in_ready", 32'(bus.in_ready), 32'd0);
    chk("busy_out_valid", 32'(bus.out_valid), 32'd0);
    chk("drive_x", 32'(div_x), 32'd13);
    chk("drive_y", 32'(div_y), 32'd3);
    @(negedge clk);
    chk("normal_latency", 32'(bus.out_valid), 32'd1);
    chk("ready_again", 32'(bus.in_ready), 32'd1);
    step();

    // Divide-by-zero: result at the accepting edge, divider operands untouched.
    send(5, 0, mk(7, 0, 1, 0), 1);
    @(negedge clk);
    chk("error_latency", 32'(bus.out_valid), 32'd1);
    chk("dbz_hold_x", 32'(div_x), 32'd13);
    chk("dbz_hold_y", 32'(div_y), 32'd3);
    step();

    send(9, 1, mk(7, 0, 0, 1), 1);
    send(7, 1, mk(7, 0, 0, 0), 1);
    send(15, 2, mk(7, 1, 0, 0), 1);
    drain();

    // Backpressure: two results fill the FIFO, the third request is held off.
    bus.out_ready = 1'b0;
    send(6, 2, mk(3, 0, 0, 0), 1);
    send(7, 3, mk(2, 1, 0, 0), 1);
    fork
      send(8, 3, mk(2, 2, 0, 0), 1);
      begin
        repeat (3) step();
        @(negedge clk);
        chk("full_in_ready", 32'(bus.in_ready), 32'd0);
        chk("full_out_valid", 32'(bus.out_valid), 32'd1);
        chk("full_head_q", 32'(bus.out_q), 32'd3);
        chk("held_off", 32'(exp_q.size()), 32'd2);
        step();
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Reset during the drive phase drops the request.
    send(11, 2, mk(5, 1, 0, 0), 0);
    reset = 1'b1;
    @(negedge clk);
    chk("in_ready_mid_reset", 32'(bus.in_ready), 32'd0);
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_zero", {bus.out_valid, bus.out_q, bus.out_r, bus.out_dbz, bus.out_ovf,
                            div_x, div_y}, 32'd0);
    repeat (2) @(negedge clk);
    chk("no_dropped_push", 32'(bus.out_valid), 32'd0);
    step();
    send(4, 2, mk(2, 0, 0, 0), 1);
    drain();

    // Full sweep with random consumer stalls.
    rand_en = 1;
    fork
      begin
        while (rand_en) begin
          bus.out_ready = 1'($urandom_range(0, 1));
          step();
        end
      end
      begin
        for (int x = 0; x < 16; x++) begin
          for (int y = 0; y < 4; y++) begin
            send(x, y, model(x, y), 1);
          end
        end
        rand_en = 0;
      end
    join
    bus.out_ready = 1'b1;
    drain();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
